// File: rtl/addsub_accum.sv
// Accumulation stage: folds a stream of 8-bit signed/unsigned add/sub beats into
// an ACC_W-bit total, emitting sum, sticky overflow and beat count per group.
// Define ADDSUB_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module addsub_accum #(
  parameter int ACC_W   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_signed,
  input  logic               in_op,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               accept;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W:0]     wide;
  logic [ACC_W-1:0]   res;
  logic               beat_ovf;
  logic [ACC_W-1:0]   acc_next;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  // The output fields are the accumulator registers themselves; they only
  // change on an accepted beat or on the output handshake, so they are stable
  // for the whole HOLD period.
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

  // Arithmetic for the beat currently presented.
  always_comb begin
    ext  = in_signed ? {{(ACC_W-8){in_data[7]}}, in_data}
                     : {{(ACC_W-8){1'b0}}, in_data};
    wide = in_op ? ({1'b0, acc_q} - {1'b0, ext})
                 : ({1'b0, acc_q} + {1'b0, ext});
    res  = wide[ACC_W-1:0];
    // Signed: add needs equal operand signs, sub needs different ones; the
    // overflow shows as the result sign departing from the accumulator sign.
    if (in_signed) begin
      beat_ovf = ((acc_q[ACC_W-1] ^ ext[ACC_W-1]) == in_op) &&
                 (res[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      beat_ovf = wide[ACC_W];
    end
  end

`ifdef ADDSUB_ACCUM_SAT_EN
  always_comb begin
    acc_next = res;
    if (beat_ovf) begin
      if (in_signed) begin
        // A signed overflow always moves away from zero in the accumulator's direction.
        acc_next = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next = in_op ? '0 : '1;
      end
    end
  end
`else
  assign acc_next = res;
`endif

  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_next;
          ovf_d   = ovf_q | beat_ovf;
          count_d = (count_q == '1) ? count_q : count_q + COUNT_ONE;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// Self-checking bench for addsub_accum: directed groups plus randomised groups,
// with expected results from an integer-arithmetic reference model queued per group.
module tb_addsub_accum;

  localparam int ACC_W   = 16;
  localparam int COUNT_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0]   sum;
    logic               ovf;
    logic [COUNT_W-1:0] cnt;
  } res_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_signed;
  logic               in_op;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               out_ovf;
  logic [COUNT_W-1:0] out_count;

  int total = 0;
  int bad   = 0;

  res_t exp_q[$];
  logic [ACC_W-1:0]   m_acc;
  logic               m_ovf;
  logic [COUNT_W-1:0] m_cnt;

  addsub_accum #(.ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic string show(res_t r);
    return $sformatf("sum=%h ovf=%b cnt=%0d", r.sum, r.ovf, r.cnt);
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.sum = out_sum;
    r.ovf = out_ovf;
    r.cnt = out_count;
    return r;
  endfunction

  function automatic res_t pop_exp();
    res_t r;
    r = '0;
    if (exp_q.size() > 0) r = exp_q.pop_front();
    return r;
  endfunction

  task automatic model_clear();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  // Reference: exact integer result checked against the representable range.
  task automatic model_beat(input logic [7:0] d, input logic s, input logic o, input logic l);
    longint a, e, r, lo, hi;
    res_t   p;
    if (s) begin
      a  = longint'($signed(m_acc));
      e  = longint'($signed(d));
      lo = -(longint'(1) << (ACC_W-1));
      hi = (longint'(1) << (ACC_W-1)) - 1;
    end else begin
      a  = longint'(m_acc);
      e  = longint'(d);
      lo = 0;
      hi = (longint'(1) << ACC_W) - 1;
    end
    r = o ? a - e : a + e;
    if (r < lo || r > hi) m_ovf = 1'b1;
`ifdef ADDSUB_ACCUM_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`endif
    m_acc = r[ACC_W-1:0];
    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (l) begin
      p.sum = m_acc;
      p.ovf = m_ovf;
      p.cnt = m_cnt;
      exp_q.push_back(p);
      model_clear();
    end
  endtask

  // Presents one beat at a negedge and returns at the negedge after it is taken.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic o, input logic l);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    in_op     = o;
    in_last   = l;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_beat(d, s, o, l);
  endtask

  // Waits for out_valid, captures the result, stalls, then completes the handshake.
  task automatic collect(input int stall, output res_t obs);
    int n;
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
    obs = dut_res();
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    in_op     = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_sum, out_ovf, out_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b %s, required all zero", out_valid, show(dut_res()));
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_unsigned_add();
    res_t obs, e;
    send_beat(8'd200, 1'b0, 1'b0, 1'b0);
    send_beat(8'd100, 1'b0, 1'b0, 1'b0);
    send_beat(8'd50,  1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL uadd_latency: got out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
    collect(0, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs !== res_t'{16'h015E, 1'b0, 8'd3}) begin
      bad++;
      $display("FAIL uadd_result: got %s, required %s", show(obs), show(e));
    end
  endtask

  task automatic test_signed_add();
    res_t obs, e;
    send_beat(8'h80, 1'b1, 1'b0, 1'b0);
    send_beat(8'h80, 1'b1, 1'b0, 1'b1);
    collect(0, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs !== res_t'{16'hFF00, 1'b0, 8'd2}) begin
      bad++;
      $display("FAIL sadd_result: got %s, required %s", show(obs), show(e));
    end
  endtask

  task automatic test_unsigned_sub();
    res_t obs, e, lit;
`ifdef ADDSUB_ACCUM_SAT_EN
    lit = res_t'{16'h0000, 1'b1, 8'd1};
`else
    lit = res_t'{16'hFFFB, 1'b1, 8'd1};
`endif
    send_beat(8'd5, 1'b0, 1'b1, 1'b1);
    collect(0, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs !== lit) begin
      bad++;
      $display("FAIL usub_result: got %s, required %s", show(obs), show(lit));
    end
  endtask

  task automatic test_hold_stall();
    res_t cap, e;
    int n;
    out_ready = 1'b0;
    send_beat(8'd3, 1'b0, 1'b0, 1'b0);
    send_beat(8'd4, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cap = dut_res();
    e = pop_exp();
    total++;
    if (cap !== e) begin
      bad++;
      $display("FAIL hold_result: got %s, required %s", show(cap), show(e));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (dut_res() !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: got %s valid=%b in_ready=%b, required %s valid=1 in_ready=0",
                 i, show(dut_res()), out_valid, in_ready, show(e));
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== '0) begin
      bad++;
      $display("FAIL hold_release: got valid=%b in_ready=%b %s, required 0/1 and cleared",
               out_valid, in_ready, show(dut_res()));
    end
  endtask

  task automatic test_reset_mid_group();
    res_t obs, e;
    send_beat(8'd10, 1'b0, 1'b0, 1'b0);
    send_beat(8'd20, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    model_clear();
    exp_q.delete();
    @(negedge clk);
    total++;
    if (out_count !== '0 || out_sum !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: got valid=%b %s, required cleared", out_valid, show(dut_res()));
    end
    reset = 1'b0;
    @(negedge clk);
    send_beat(8'd7, 1'b0, 1'b0, 1'b1);
    collect(1, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs !== res_t'{16'd7, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL midreset_result: got %s, required %s", show(obs), show(e));
    end
  endtask

  task automatic test_long_groups();
    res_t obs, e;
    for (int i = 1; i <= 300; i++) send_beat(8'd1, 1'b0, 1'b0, i == 300);
    collect(0, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs !== res_t'{16'd300, 1'b0, 8'd255}) begin
      bad++;
      $display("FAIL count_sat: got %s, required %s", show(obs), show(e));
    end
    // Signed positive overflow: 259 * 127 exceeds 32767.
    for (int i = 1; i <= 259; i++) send_beat(8'd127, 1'b1, 1'b0, i == 259);
    collect(0, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs.ovf !== 1'b1) begin
      bad++;
      $display("FAIL signed_ovf: got %s, required %s", show(obs), show(e));
    end
    // Unsigned carry overflow: 258 * 255 exceeds 65535.
    for (int i = 1; i <= 258; i++) send_beat(8'd255, 1'b0, 1'b0, i == 258);
    collect(2, obs);
    e = pop_exp();
    total++;
    if (obs !== e || obs.ovf !== 1'b1) begin
      bad++;
      $display("FAIL unsigned_ovf: got %s, required %s", show(obs), show(e));
    end
  endtask

  task automatic test_random();
    res_t obs, e;
    int len;
    for (int g = 0; g < 25; g++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), b == len - 1);
      end
      collect($urandom_range(0, 3), obs);
      e = pop_exp();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random_group[%0d]: got %s, required %s", g, show(obs), show(e));
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_add();
    test_signed_add();
    test_unsigned_sub();
    test_hold_stall();
    test_reset_mid_group();
    test_long_groups();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
